// File: rtl/pin_entry_ctrl.sv
`default_nettype none
// ============================================================================
// pin_entry_ctrl : debounced five-button BCD digit entry, auto-repeat, timeout
// Rev 1.0
// ============================================================================
module pin_entry_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DB_COUNT     = 1000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 12500000,
  parameter int TIMEOUT      = 1500000000
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    en,
  input  logic [4:0]                                              btn,
  output logic [4*NUM_DIGITS-1:0]                                 digits_out,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] sel,
  output logic [4*NUM_DIGITS-1:0]                                 data_out,
  output logic                                                    data_valid,
  output logic                                                    timeout
);

  localparam int SW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DBW  = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [DBW-1:0] c_db_last   = DBW'(DB_COUNT - 1);
  localparam logic [RW-1:0]  c_dly_last  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  c_rate_last = RW'(REPEAT_RATE - 1);
  localparam logic [TW-1:0]  c_to_last   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0]  c_sel_last  = SW'(NUM_DIGITS - 1);
  localparam logic [4:0]     c_mask_up   = 5'b00100;
  localparam logic [4:0]     c_mask_dn   = 5'b01000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } rep_state_t;

  logic [4:0]                  w_lvl;
  logic [4:0]                  r_lvl_d;
  logic [4:0]                  w_press;
  logic [4:0]                  w_rep_mask;
  logic [4:0]                  w_ev;
  logic                        w_held;
  logic                        w_other;
  logic                        w_rep_fire;
  logic                        w_single;
  logic                        w_qual;
  logic                        w_empty;
  logic [3:0]                  w_cur;

  rep_state_t                  r_state;
  rep_state_t                  w_state_nxt;
  logic [RW-1:0]               r_rep_cnt;
  logic [RW-1:0]               w_rep_cnt_nxt;
  logic                        r_rep_dn;
  logic                        w_rep_dn_nxt;

  logic [NUM_DIGITS-1:0][3:0]  r_digits;
  logic [SW-1:0]               r_sel;
  logic [4*NUM_DIGITS-1:0]     r_data;
  logic                        r_valid;
  logic                        r_timeout;
  logic [TW-1:0]               r_to_cnt;

  // Per-button integrator: the level only moves after DB_COUNT stable disagreeing samples.
  for (genvar gi = 0; gi < 5; gi++) begin : g_db
    logic [DBW-1:0] r_cnt;
    logic           r_lvl;

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (btn[gi] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == c_db_last) begin
        r_cnt <= '0;
        r_lvl <= btn[gi];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_lvl[gi] = r_lvl;
  end

  assign w_press    = w_lvl & ~r_lvl_d;
  assign w_rep_mask = r_rep_dn ? c_mask_dn : c_mask_up;
  assign w_held     = |(w_lvl & w_rep_mask);
  assign w_other    = |(w_press & ~w_rep_mask);
  assign w_rep_fire = w_held &&
                      (((r_state == S_DELAY)  && (r_rep_cnt == c_dly_last)) ||
                       ((r_state == S_REPEAT) && (r_rep_cnt == c_rate_last)));
  assign w_ev       = w_press | (w_rep_fire ? w_rep_mask : 5'b00000);
  // Exactly one bit set: any coincident events cancel each other.
  assign w_single   = (w_ev != 5'd0) && ((w_ev & (w_ev - 5'd1)) == 5'd0);
  assign w_qual     = en && w_single;
  assign w_empty    = (r_digits == '0) && (r_sel == '0);
  assign w_cur      = r_digits[r_sel];

  always_comb begin
    w_state_nxt   = r_state;
    w_rep_cnt_nxt = r_rep_cnt + 1'b1;
    w_rep_dn_nxt  = r_rep_dn;
    case (r_state)
      S_IDLE: begin
        w_rep_cnt_nxt = '0;
        if (w_qual && (w_ev[2] || w_ev[3])) begin
          w_state_nxt  = S_DELAY;
          w_rep_dn_nxt = w_ev[3];
        end
      end
      S_DELAY, S_REPEAT: begin
        if (!en || !w_held || w_other) begin
          w_state_nxt   = S_IDLE;
          w_rep_cnt_nxt = '0;
        end else if (w_rep_fire) begin
          w_state_nxt   = S_REPEAT;
          w_rep_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_rep_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rep_cnt <= '0;
      r_rep_dn  <= 1'b0;
      r_lvl_d   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
      r_rep_dn  <= w_rep_dn_nxt;
      r_lvl_d   <= w_lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_digits  <= '0;
      r_sel     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      if (w_qual) begin
        r_to_cnt <= '0;
        if (w_ev[0]) r_sel <= (r_sel == c_sel_last) ? '0 : r_sel + 1'b1;
        if (w_ev[1]) r_sel <= (r_sel == '0) ? c_sel_last : r_sel - 1'b1;
        if (w_ev[2]) r_digits[r_sel] <= (w_cur == 4'd9) ? 4'd0 : w_cur + 4'd1;
        if (w_ev[3]) r_digits[r_sel] <= (w_cur == 4'd0) ? 4'd9 : w_cur - 4'd1;
        if (w_ev[4]) begin
          r_data   <= r_digits;
          r_valid  <= 1'b1;
          r_digits <= '0;
          r_sel    <= '0;
        end
      end else if (!en || w_empty) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == c_to_last) begin
        r_to_cnt  <= '0;
        r_digits  <= '0;
        r_sel     <= '0;
        r_timeout <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign digits_out = r_digits;
  assign sel        = r_sel;
  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pin_entry_ctrl.sv
`default_nettype none
// Bench for pin_entry_ctrl: table of button presses with scoreboarded expectations,
// plus hand-written sequences for bounce, auto-repeat, enable, timeout and reset.
module tb_pin_entry_ctrl;

  localparam logic [4:0] B_L = 5'b00001;
  localparam logic [4:0] B_R = 5'b00010;
  localparam logic [4:0] B_U = 5'b00100;
  localparam logic [4:0] B_D = 5'b01000;
  localparam logic [4:0] B_C = 5'b10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [4:0]  btn;
  logic [15:0] digits_out;
  logic [1:0]  sel;
  logic [15:0] data_out;
  logic        data_valid;
  logic        timeout;

  pin_entry_ctrl #(
    .NUM_DIGITS  (4),
    .DB_COUNT    (4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (5),
    .TIMEOUT     (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .btn       (btn),
    .digits_out(digits_out),
    .sel       (sel),
    .data_out  (data_out),
    .data_valid(data_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  b;
    logic [15:0] dig;
    logic [1:0]  s;
    logic [15:0] data;
  } vec_t;

  typedef struct packed {
    logic [15:0] dig;
    logic [1:0]  s;
    logic [15:0] data;
  } exp_t;

  vec_t vecs [18];
  exp_t sb_q [$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   valid_cnt = 0;
  int   to_cnt    = 0;

  always @(negedge clk) begin
    if (data_valid) valid_cnt++;
    if (timeout)    to_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [15:0] dig, input logic [1:0] s, input logic [15:0] data);
    exp_t e;
    e.dig  = dig;
    e.s    = s;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({name, "_digits"}, {16'd0, digits_out}, {16'd0, e.dig});
      check({name, "_sel"},    {30'd0, sel},        {30'd0, e.s});
      check({name, "_data"},   {16'd0, data_out},   {16'd0, e.data});
    end
  endtask

  // Raw button held for 'hold' sampled edges, then released long enough to debounce low.
  task automatic press(input logic [4:0] b, input int hold);
    btn = b;
    repeat (hold) @(posedge clk);
    #1 btn = 5'd0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    int changed_at;

    vecs[0]  = '{B_U, 16'h0001, 2'd0, 16'h0000};
    vecs[1]  = '{B_U, 16'h0002, 2'd0, 16'h0000};
    vecs[2]  = '{B_U, 16'h0003, 2'd0, 16'h0000};
    vecs[3]  = '{B_U, 16'h0004, 2'd0, 16'h0000};
    vecs[4]  = '{B_L, 16'h0004, 2'd1, 16'h0000};
    vecs[5]  = '{B_U, 16'h0014, 2'd1, 16'h0000};
    vecs[6]  = '{B_U, 16'h0024, 2'd1, 16'h0000};
    vecs[7]  = '{B_U, 16'h0034, 2'd1, 16'h0000};
    vecs[8]  = '{B_L, 16'h0034, 2'd2, 16'h0000};
    vecs[9]  = '{B_U, 16'h0134, 2'd2, 16'h0000};
    vecs[10] = '{B_U, 16'h0234, 2'd2, 16'h0000};
    vecs[11] = '{B_L, 16'h0234, 2'd3, 16'h0000};
    vecs[12] = '{B_U, 16'h1234, 2'd3, 16'h0000};
    vecs[13] = '{B_C, 16'h0000, 2'd0, 16'h1234};
    vecs[14] = '{B_D, 16'h0009, 2'd0, 16'h1234};
    vecs[15] = '{B_U, 16'h0000, 2'd0, 16'h1234};
    vecs[16] = '{B_R, 16'h0000, 2'd3, 16'h1234};
    vecs[17] = '{B_L, 16'h0000, 2'd0, 16'h1234};

    rst = 1'b0;
    en  = 1'b0;
    btn = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits",  {16'd0, digits_out}, 32'd0);
    check("rst_sel",     {30'd0, sel},        32'd0);
    check("rst_data",    {16'd0, data_out},   32'd0);
    check("rst_valid",   {31'd0, data_valid}, 32'd0);
    check("rst_timeout", {31'd0, timeout},    32'd0);
    rst = 1'b1;
    en  = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Entry sequence 1234, submit, then wrap cases
    for (int i = 0; i < 18; i++) begin
      sb_push(vecs[i].dig, vecs[i].s, vecs[i].data);
      press(vecs[i].b, 10);
      sb_check($sformatf("vec%0d", i));
    end
    check("entry_valid_pulses", valid_cnt, 32'd1);

    // Bounce: three high samples are not enough
    btn = B_U;
    repeat (3) @(posedge clk);
    #1 btn = 5'd0;
    repeat (10) @(posedge clk);
    #1;
    sb_push(16'h0000, 2'd0, 16'h1234);
    sb_check("bounce_short");

    // Four high samples register, visible within six edges of the raw rise
    btn = B_U;
    changed_at = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) btn = 5'd0;
      if (changed_at == 0 && digits_out == 16'h0001) changed_at = k;
    end
    check("bounce_latency_ok", {31'd0, (changed_at != 0)}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    sb_push(16'h0001, 2'd0, 16'h1234);
    sb_check("bounce_exact");

    sb_push(16'h0000, 2'd0, 16'h1234);
    press(B_D, 10);
    sb_check("down_to_zero");

    // Auto-repeat: debounced high for 31 cycles -> press + repeats at +20, +25, +30
    btn = B_U;
    repeat (31) @(posedge clk);
    #1 btn = 5'd0;
    repeat (15) @(posedge clk);
    #1;
    sb_push(16'h0004, 2'd0, 16'h1234);
    sb_check("auto_repeat");

    // Left pressed during an Up hold stops the repeat
    btn = B_U;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (k == 27) btn = B_U | B_L;
      if (k == 33) btn = B_U;
    end
    btn = 5'd0;
    repeat (15) @(posedge clk);
    #1;
    sb_push(16'h0007, 2'd1, 16'h1234);
    sb_check("left_stops_repeat");

    sb_push(16'h0007, 2'd1, 16'h1234);
    press(B_U | B_L, 10);
    sb_check("simultaneous");

    en = 1'b0;
    press(B_U, 10);
    press(B_D, 10);
    press(B_L, 10);
    press(B_R, 10);
    press(B_C, 10);
    sb_push(16'h0007, 2'd1, 16'h1234);
    sb_check("en_low");
    check("en_low_valid_pulses", valid_cnt, 32'd1);

    // Up already held when en rises
    btn = B_U;
    repeat (10) @(posedge clk);
    #1 en = 1'b1;
    repeat (30) @(posedge clk);
    #1 btn = 5'd0;
    repeat (10) @(posedge clk);
    #1;
    sb_push(16'h0007, 2'd1, 16'h1234);
    sb_check("held_across_en");
    check("no_early_timeout", to_cnt, 32'd0);

    sb_push(16'h0000, 2'd0, 16'h0007);
    press(B_C, 10);
    sb_check("submit2");
    check("submit2_valid_pulses", valid_cnt, 32'd2);

    for (int i = 0; i < 5; i++) begin
      sb_push(16'(i + 1), 2'd0, 16'h0007);
      press(B_U, 10);
      sb_check($sformatf("enter5_%0d", i));
    end

    // Idle: no timeout yet at ~85 cycles, then it must arrive
    repeat (70) @(posedge clk);
    #1;
    check("timeout_not_yet", to_cnt, 32'd0);
    sb_push(16'h0005, 2'd0, 16'h0007);
    sb_check("before_timeout");
    for (int k = 0; k < 60 && to_cnt == 0; k++) @(posedge clk);
    #1;
    check("timeout_pulses", to_cnt, 32'd1);
    sb_push(16'h0000, 2'd0, 16'h0007);
    sb_check("after_timeout");

    // Reset mid-repeat
    btn = B_U;
    repeat (27) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_digits",  {16'd0, digits_out}, 32'd0);
    check("midrst_sel",     {30'd0, sel},        32'd0);
    check("midrst_data",    {16'd0, data_out},   32'd0);
    check("midrst_valid",   {31'd0, data_valid}, 32'd0);
    check("midrst_timeout", {31'd0, timeout},    32'd0);
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1 btn = 5'd0;
    repeat (10) @(posedge clk);
    #1;
    sb_push(16'h0001, 2'd0, 16'h0000);
    sb_check("after_midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
